serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/full_adder_usg_2HA.sv | 25 ++
 rtl/serial_adder.sv | 124 ++++++++++++
 tb/tb_serial_adder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and counter sizing.
package serial_adder_pkg;

  // Controller states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit counter width. The extra bit keeps WIDTH=1 legal ($clog2(1) is 0).
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage : serial_adder_pkg

// File: rtl/full_adder_usg_2HA.sv
// 1-bit full adder built from two half adders plus an OR for the carry.
module full_adder_usg_2HA (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ha1_s;
  logic ha1_c;
  logic ha2_c;

  // First half adder combines the two operand bits.
  assign ha1_s = a ^ b;
  assign ha1_c = a & b;

  // Second half adder folds in the incoming carry.
  assign s     = ha1_s ^ cin;
  assign ha2_c = ha1_s & cin;

  // At most one half adder can generate a carry, so OR is sufficient.
  assign cout  = ha1_c | ha2_c;

endmodule : full_adder_usg_2HA

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder and a carry flop process the operands
// LSB first, one bit per clock, with registered Sum/Carry and a done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_reg;
  state_t             state_next;

  logic [WIDTH-1:0]   a_sr_reg;
  logic [WIDTH-1:0]   b_sr_reg;
  logic [WIDTH-1:0]   s_sr_reg;
  logic               c_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               carry_reg;

  logic               fa_s;
  logic               fa_c;
  logic               last_bit;
  logic [WIDTH-1:0]   a_shift;
  logic [WIDTH-1:0]   b_shift;
  logic [WIDTH-1:0]   s_shift;

  // The single shared full adder works on the current LSBs and stored carry.
  full_adder_usg_2HA u_fa (
    .a    (a_sr_reg[0]),
    .b    (b_sr_reg[0]),
    .cin  (c_reg),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Bit index WIDTH-1 is being processed in this cycle.
  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

  // Shifted register images; the new sum bit enters at the MSB so that after
  // WIDTH shifts the first (LSB) result bit has arrived at bit 0.
  always_comb begin
    a_shift            = a_sr_reg >> 1;
    b_shift            = b_sr_reg >> 1;
    s_shift            = s_sr_reg >> 1;
    s_shift[WIDTH-1]   = fa_s;
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: start only matters in IDLE, DONE always lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start)    state_next = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_next = ST_DONE;
      ST_DONE:                state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, serial shifting, carry, counter and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      s_sr_reg  <= '0;
      c_reg     <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_sr_reg <= A;
            b_sr_reg <= B;
            c_reg    <= Cin;
            cnt_reg  <= '0;
          end
        end
        ST_SHIFT: begin
          a_sr_reg <= a_shift;
          b_sr_reg <= b_shift;
          s_sr_reg <= s_shift;
          c_reg    <= fa_c;
          cnt_reg  <= cnt_reg + CNT_W'(1);
          // Outputs only ever update with a complete result.
          if (last_bit) begin
            sum_reg   <= s_shift;
            carry_reg <= fa_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy  = (state_reg != ST_IDLE);
  assign done  = (state_reg == ST_DONE);
  assign Sum   = sum_reg;
  assign Carry = carry_reg;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors on WIDTH=8 and
// WIDTH=1 instances, reset abort, ignored start and a back-to-back run.
module tb_serial_adder;

  logic       clk;
  logic       rst;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       carry8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       carry1;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .A     (a8),
    .B     (b8),
    .Cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .Sum   (sum8),
    .Carry (carry8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .A     (a1),
    .B     (b1),
    .Cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .Sum   (sum1),
    .Carry (carry1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse on the 8-bit instance; returns 1 ns after edge 0.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a8     = a;
    b8     = b;
    cin8   = c;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
  endtask

  // Step edges until done (bounded); reports edges taken and busy samples.
  task automatic wait_done8(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = busy8 ? 1 : 0;
    while (!done8 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (busy8) busy_cycles++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy8, done8, sum8, carry8} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset8: busy=%b done=%b Sum=%h Carry=%b, required all 0", busy8, done8, sum8, carry8);
    end
    n_checks++;
    if ({busy1, done1, sum1, carry1} !== 4'd0) begin
      n_fail++;
      $display("FAIL reset1: busy=%b done=%b Sum=%h Carry=%b, required all 0", busy1, done1, sum1, carry1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_basic;
    int cyc;
    int bcyc;
    start_op8(8'h5A, 8'h3C, 1'b0);
    wait_done8(cyc, bcyc);
    n_checks++;
    if (cyc !== 8) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles, required 8", cyc);
    end
    n_checks++;
    if ({carry8, sum8} !== 9'h096) begin
      n_fail++;
      $display("FAIL basic_result: Carry=%b Sum=%h, required Carry=0 Sum=96", carry8, sum8);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bcyc !== 9 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: busy cycles=%0d busy=%b done=%b after, required 9/0/0", bcyc, busy8, done8);
    end
    $display("basic: 5A+3C+0 -> %b_%h latency %0d busy %0d", carry8, sum8, cyc, bcyc);
  endtask

  task automatic test_carry;
    int cyc;
    int bcyc;
    start_op8(8'hFF, 8'h01, 1'b0);
    wait_done8(cyc, bcyc);
    n_checks++;
    if (cyc !== 8 || {carry8, sum8} !== 9'h100) begin
      n_fail++;
      $display("FAIL carry_ff01: Carry=%b Sum=%h lat=%0d, required Carry=1 Sum=00 lat=8", carry8, sum8, cyc);
    end
    $display("carry: FF+01+0 -> %b_%h", carry8, sum8);
    @(posedge clk);
    #1;
    start_op8(8'hFF, 8'hFF, 1'b1);
    wait_done8(cyc, bcyc);
    n_checks++;
    if (cyc !== 8 || {carry8, sum8} !== 9'h1FF) begin
      n_fail++;
      $display("FAIL carry_ffff1: Carry=%b Sum=%h lat=%0d, required Carry=1 Sum=FF lat=8", carry8, sum8, cyc);
    end
    $display("carry: FF+FF+1 -> %b_%h", carry8, sum8);
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignored_start;
    int dones = 0;
    start_op8(8'h12, 8'h34, 1'b0);
    repeat (3) begin
      @(posedge clk);
      if (done8) dones++;
    end
    @(negedge clk);
    a8     = 8'hFF;
    b8     = 8'hFF;
    cin8   = 1'b1;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    n_checks++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL ignored_start_dones: got %0d done pulses, required 1", dones);
    end
    n_checks++;
    if ({carry8, sum8} !== 9'h046 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start_result: Carry=%b Sum=%h busy=%b, required Carry=0 Sum=46 busy=0", carry8, sum8, busy8);
    end
    $display("ignored_start: 12+34+0 -> %b_%h dones %0d", carry8, sum8, dones);
  endtask

  task automatic test_reset_abort;
    int cyc;
    int bcyc;
    int dones = 0;
    start_op8(8'hAA, 8'h55, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy8, done8, sum8, carry8} !== 11'd0) begin
      n_fail++;
      $display("FAIL abort_async: busy=%b done=%b Sum=%h Carry=%b, required all 0", busy8, done8, sum8, carry8);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done8 || busy8) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet: %0d busy/done cycles after abort, required 0", dones);
    end
    start_op8(8'h70, 8'h05, 1'b1);
    wait_done8(cyc, bcyc);
    n_checks++;
    if (cyc !== 8 || {carry8, sum8} !== 9'h076) begin
      n_fail++;
      $display("FAIL abort_fresh: Carry=%b Sum=%h lat=%0d, required Carry=0 Sum=76 lat=8", carry8, sum8, cyc);
    end
    $display("reset_abort: fresh 70+05+1 -> %b_%h", carry8, sum8);
    @(posedge clk);
    #1;
  endtask

  task automatic test_width1;
    logic [2:0] v;
    logic [1:0] exp;
    int cyc;
    for (int i = 0; i < 8; i++) begin
      v   = 3'(i);
      exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      @(negedge clk);
      a1     = v[2];
      b1     = v[1];
      cin1   = v[0];
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      cyc    = 0;
      while (!done1 && cyc < 10) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      n_checks++;
      if (cyc !== 1 || {carry1, sum1} !== exp) begin
        n_fail++;
        $display("FAIL width1_%0d: {Carry,Sum}=%b lat=%0d, required %b lat=1", i, {carry1, sum1}, cyc, exp);
      end
      $display("width1: %b+%b+%b -> %b", v[2], v[1], v[0], {carry1, sum1});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp_q[$];
    logic [8:0] exp;
    int         ops       = 0;
    int         cycle     = 0;
    int         last_done = -1;
    int         bad_space = 0;
    int         bad_res   = 0;
    while (ops < 1000 && cycle < 15000) begin
      @(negedge clk);
      cycle++;
      if (done8) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h000;
        n_checks++;
        if ({carry8, sum8} !== exp) begin
          n_fail++;
          bad_res++;
          if (bad_res < 10)
            $display("FAIL b2b_result op %0d: {Carry,Sum}=%h, required %h", ops, {carry8, sum8}, exp);
        end
        if (last_done >= 0) begin
          n_checks++;
          if (cycle - last_done !== 10) begin
            n_fail++;
            bad_space++;
            if (bad_space < 10)
              $display("FAIL b2b_spacing op %0d: spacing %0d, required 10", ops, cycle - last_done);
          end
        end
        last_done = cycle;
        ops++;
      end
      if (!busy8) begin
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        cin8   = 1'($urandom);
        start8 = 1'b1;
        exp_q.push_back(9'(a8) + 9'(b8) + 9'(cin8));
      end
    end
    start8 = 1'b0;
    n_checks++;
    if (ops !== 1000) begin
      n_fail++;
      $display("FAIL b2b_count: %0d operations completed, required 1000", ops);
    end
    for (int i = 0; i < 20 && busy8; i++) @(negedge clk);
    $display("back_to_back: %0d ops, %0d result errors, %0d spacing errors", ops, bad_res, bad_space);
  endtask

  initial begin
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    cin8   = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    cin1   = 1'b0;
    test_reset;
    test_basic;
    test_carry;
    test_ignored_start;
    test_reset_abort;
    test_width1;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_adder
